// File: rtl/mul_seq_nbit.sv
// Iterative radix-2 shift-add multiplier, signed/unsigned per operation.
// Optional early exit on an exhausted multiplier: define MUL_SEQ_EARLY_EXIT_EN.
module mul_seq_nbit #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] r,
  output logic           busy
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]     mplr_q, mplr_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic [2*N-1:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;

  logic [N-1:0]     x_abs, y_abs;
  logic [2*N-1:0]   add_term, acc_nxt;
  logic [N-1:0]     mplr_nxt;
  logic             last;

  always_comb begin
    x_abs = (sgn && x[N-1]) ? -x : x;
    y_abs = (sgn && y[N-1]) ? -y : y;
    add_term = mplr_q[0] ? mcand_q : '0;
    acc_nxt  = acc_q + add_term;
    mplr_nxt = mplr_q >> 1;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    last = (cnt_q == LAST) || (mplr_nxt == '0);
`else
    last = (cnt_q == LAST);
`endif
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = {{N{1'b0}}, x_abs};
          mplr_d  = y_abs;
          acc_d   = '0;
          cnt_d   = '0;
          neg_d   = sgn & (x[N-1] ^ y[N-1]);
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d   = acc_nxt;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_nxt;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          // sign is applied once to the final magnitude
          r_d     = neg_q ? -acc_nxt : acc_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign r         = r_q;

endmodule

// File: tb/tb_mul_seq_nbit.sv
// Scoreboard bench for mul_seq_nbit (N=8), directed vectors.
module tb_mul_seq_nbit;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x, y;
  logic         sgn;
  logic         out_valid;
  logic         out_ready;
  logic [2*N-1:0] r;
  logic         busy;

  mul_seq_nbit #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .sgn(sgn),
    .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    int          hs;
    int          lat;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  logic prev_ov = 1'b0;
  logic [15:0] last_r = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string n, input logic [31:0] a,
                       input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < 8; i++) if (b[i]) m = i + 1;
    return (m == 0) ? 1 : m;
`else
    return N;
`endif
  endfunction

  // monitor: pops on each fresh out_valid, then guards r stability
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (q.size() == 0) begin
        check("unexpected_output", {16'h0, r}, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", {16'h0, r}, {16'h0, e.r});
        check("latency", cyc - e.hs, e.lat);
      end
      last_r = r;
    end else if (out_valid) begin
      check("r_stable", {16'h0, r}, {16'h0, last_r});
    end
    prev_ov = out_valid;
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] e,
                       output int hs);
    int k;
    exp_t t;
    k = 0;
    hs = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("issue_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    x = a;
    y = b;
    sgn = s;
    hs = cyc + 1;
    t.r = e;
    t.hs = hs;
    t.lat = exp_lat(b);
    q.push_back(t);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(q.size() == 0 && in_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int hs, hsa, k;
    exp_t t;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    sgn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_r", {16'h0, r}, 0);
    check("rst_out_valid", {31'h0, out_valid}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'h0, in_ready}, 1);

    issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, hs);
    issue(8'h80, 8'h80, 1'b1, 16'h4000, hs);
    issue(8'hFD, 8'h07, 1'b1, 16'hFFEB, hs);
    issue(8'h7F, 8'h80, 1'b1, 16'hC080, hs);
    issue(8'hFF, 8'hFF, 1'b1, 16'h0001, hs);
    issue(8'h00, 8'h80, 1'b1, 16'h0000, hs);
    issue(8'h05, 8'hFE, 1'b1, 16'hFFF6, hs);
    issue(8'h80, 8'h02, 1'b0, 16'h0100, hs);
    issue(8'h0C, 8'h0A, 1'b0, 16'h0078, hs);
    issue(8'h09, 8'h01, 1'b0, 16'h0009, hs);
    issue(8'h55, 8'h00, 1'b0, 16'h0000, hs);
    drain();

    // backpressure
    out_ready = 1'b0;
    issue(8'h11, 8'h0F, 1'b0, 16'h00FF, hs);
    k = 0;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("bp_reached_done", {31'h0, out_valid}, 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", {31'h0, out_valid}, 1);
      check("bp_in_ready", {31'h0, in_ready}, 0);
      check("bp_r", {16'h0, r}, 32'h00FF);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {31'h0, in_ready}, 1);
    check("bp_release_out_valid", {31'h0, out_valid}, 0);

    // collision: in_valid held through BUSY and DONE
    issue(8'h05, 8'h06, 1'b0, 16'h001E, hsa);
    in_valid = 1'b1;
    x = 8'h02;
    y = 8'h03;
    sgn = 1'b0;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("col_accept_cycle", cyc - hsa, exp_lat(8'h06) + 1);
    t.r = 16'h0006;
    t.hs = cyc + 1;
    t.lat = exp_lat(8'h03);
    q.push_back(t);
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // reset mid-operation
    issue(8'h12, 8'h34, 1'b0, 16'h03A8, hs);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 0);
    check("midrst_r", {16'h0, r}, 0);
    check("midrst_busy", {31'h0, busy}, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'h0, in_ready}, 1);
    issue(8'h03, 8'h05, 1'b0, 16'h000F, hs);
    drain();

    repeat (20) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
